div_32_seq: RTL and testbench

//  Iterative 32-bit restoring divider for the MIPS datapath. Inverse operation to the

---
 rtl/mips_div_pkg.sv | 9 +
 rtl/div_32_seq_if.sv | 23 ++
 rtl/div_sub_stage.sv | 14 +
 rtl/div_32_seq.sv | 127 ++++++++++++
 tb/tb_div_32_seq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_div_pkg.sv
// mips_div_pkg: shared constants and FSM state type for the sequential divider.
package mips_div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_STEPS);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_STEPS - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} div_state_t;
endpackage

// File: rtl/div_32_seq_if.sv
// div_32_seq_if: request/result bundle between the EX stage and the divider.
interface div_32_seq_if;
  import mips_div_pkg::*;
  logic                 start;
  logic                 is_signed;
  logic                 flush;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 ready;
  logic                 result_valid;
  logic                 div_by_zero;
  logic                 overflow;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  modport master (
    output start, is_signed, flush, dividend, divisor,
    input  ready, result_valid, div_by_zero, overflow, quotient, remainder
  );
  modport slave (
    input  start, is_signed, flush, dividend, divisor,
    output ready, result_valid, div_by_zero, overflow, quotient, remainder
  );
endinterface

// File: rtl/div_sub_stage.sv
// div_sub_stage: 33-bit trial subtraction of the divisor from the shifted partial remainder.
module div_sub_stage
  import mips_div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   minuend,
  input  logic [DIV_WIDTH-1:0] subtrahend,
  output logic [DIV_WIDTH-1:0] diff,
  output logic                 nonneg
);
  logic [DIV_WIDTH:0] full;
  assign full   = minuend - {1'b0, subtrahend};
  assign diff   = full[DIV_WIDTH-1:0];
  assign nonneg = !full[DIV_WIDTH];
endmodule

// File: rtl/div_32_seq.sv
// div_32_seq: iterative 32-bit restoring divider for DIV/DIVU, one trial subtract per clock.
// Define DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module div_32_seq
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic         clock,
  input logic         reset_n,
  div_32_seq_if.slave bus
);
  div_state_t       state_q, state_d;
  logic [DIV_CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, ovf_q, ovf_d;
  logic             valid_q, valid_d, dbz_q, dbz_d, ovo_q, ovo_d;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH-1:0] diff, mag_a, mag_b;
  logic             nonneg, sd, sv, ovf_in;
  assign shifted = {1'b0, rem_q, quo_q} << 1;
  div_sub_stage u_sub (
    .minuend    (shifted[2*WIDTH:WIDTH]),
    .subtrahend (dvs_q),
    .diff       (diff),
    .nonneg     (nonneg)
  );
`ifdef DIV_SIGNED_EN
  assign sd     = bus.is_signed & bus.dividend[WIDTH-1];
  assign sv     = bus.is_signed & bus.divisor[WIDTH-1];
  assign ovf_in = bus.is_signed && bus.dividend == {1'b1, {(WIDTH-1){1'b0}}} && bus.divisor == '1;
`else
  logic unused_sign;
  assign unused_sign = bus.is_signed;
  assign sd          = 1'b0;
  assign sv          = 1'b0;
  assign ovf_in      = 1'b0;
`endif
  // RUN works on magnitudes; signs are reapplied when the result is written.
  assign mag_a = sd ? -bus.dividend : bus.dividend;
  assign mag_b = sv ? -bus.divisor : bus.divisor;
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovo_d       = ovo_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        zero_d  = bus.divisor == '0;
        dvs_d   = mag_b;
        count_d = '0;
        ovf_d   = ovf_in;
        rem_d   = zero_d ? bus.dividend : '0;
        quo_d   = zero_d ? DIV_ZERO_QUOT : mag_a;
        qneg_d  = !zero_d && (sd ^ sv);
        rneg_d  = !zero_d && sd;
        state_d = zero_d ? FIXUP : RUN;
      end
      RUN: begin
        rem_d   = nonneg ? diff : shifted[2*WIDTH-1:WIDTH];
        quo_d   = {shifted[WIDTH-1:1], nonneg};
        count_d = count_q + 1'b1;
        state_d = bus.flush ? IDLE : (count_q == DIV_LAST ? FIXUP : RUN);
      end
      FIXUP: begin
        state_d = IDLE;
        if (!bus.flush) begin
          valid_d     = 1'b1;
          quotient_d  = qneg_q ? -quo_q : quo_q;
          remainder_d = rneg_q ? -rem_q : rem_q;
          dbz_d       = zero_q;
          ovo_d       = ovf_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      dbz_q       <= 1'b0;
      ovo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
      dbz_q       <= dbz_d;
      ovo_q       <= ovo_d;
    end
  end
  assign bus.ready        = state_q == IDLE;
  assign bus.result_valid = valid_q;
  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;
  assign bus.div_by_zero  = dbz_q;
  assign bus.overflow     = ovo_q;
endmodule

// File: tb/tb_div_32_seq.sv
// tb_div_32_seq: directed vectors for div_32_seq checked against an arithmetic reference model.
module tb_div_32_seq;
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } res_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   t0 = 0;
  int   edge_cnt = 0;
  logic run_chk = 1'b0;
  div_32_seq_if bus ();
  div_32_seq dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t x;
    x = '0;
    if (b == 0) begin
      x.q = 32'hFFFF_FFFF;
      x.r = a;
      x.dbz = 1'b1;
    end
`ifdef DIV_SIGNED_EN
    else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      x.q = a;
      x.ovf = 1'b1;
    end else if (s) begin
      x.q = 32'($signed(a) / $signed(b));
      x.r = 32'($signed(a) % $signed(b));
    end
`endif
    else begin
      x.q = a / b;
      x.r = a % b;
    end
    return x;
  endfunction
  // Reference model: accept when idle, deliver after the fixed latency, abort on flush.
  logic m_busy, m_valid;
  int   m_left;
  res_t m_pend, m_out;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_pend  <= '0;
      m_out   <= '0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1'b1;
          m_left <= (bus.divisor == 0) ? 1 : 33;
          m_pend <= ref_div(bus.dividend, bus.divisor, bus.is_signed);
        end
      end else if (bus.flush) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_out   <= m_pend;
      end else m_left <= m_left - 1;
    end
  end
  always @(negedge clock) if (run_chk) begin
    chk("ready", 32'(bus.ready), 32'(!m_busy));
    chk("result_valid", 32'(bus.result_valid), 32'(m_valid));
    chk("quotient", bus.quotient, m_out.q);
    chk("remainder", bus.remainder, m_out.r);
    if (m_valid) begin
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_out.dbz));
      chk("overflow", 32'(bus.overflow), 32'(m_out.ovf));
    end
  end
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    bus.is_signed = s;
    t0 = edge_cnt + 1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask
  task automatic wait_res(input string name, input logic [31:0] q, input logic [31:0] r,
                          input logic dbz, input logic ovf, input int lat);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clock);
      seen = bus.result_valid;
    end
    if (!seen) chk({name, "_timeout"}, 32'(0), 32'(1));
    else begin
      chk({name, "_lat"}, 32'(edge_cnt - t0), 32'(lat));
      chk({name, "_q"}, bus.quotient, q);
      chk({name, "_r"}, bus.remainder, r);
      chk({name, "_dbz"}, 32'(bus.div_by_zero), 32'(dbz));
      chk({name, "_ovf"}, 32'(bus.overflow), 32'(ovf));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nv;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.flush = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clock);
    run_chk = 1'b1;
    chk("rst_ready", 32'(bus.ready), 32'(1));
    chk("rst_valid", 32'(bus.result_valid), 32'(0));
    chk("rst_q", bus.quotient, 32'h0);
    chk("rst_r", bus.remainder, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    launch(32'd100, 32'd7, 1'b0);
    wait_res("divu_100_7", 32'd14, 32'd2, 1'b0, 1'b0, 33);
    launch(32'h1234, 32'h0, 1'b0);
    wait_res("div0", 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1);
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
`ifdef DIV_SIGNED_EN
    wait_res("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
`else
    wait_res("div_m7_2", 32'h7FFF_FFFC, 32'h1, 1'b0, 1'b0, 33);
`endif
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
`ifdef DIV_SIGNED_EN
    wait_res("div_ovf", 32'h8000_0000, 32'h0, 1'b0, 1'b1, 33);
`else
    wait_res("div_ovf", 32'h0, 32'h8000_0000, 1'b0, 1'b0, 33);
`endif
    launch(32'h7, 32'hFFFF_FFFE, 1'b1);
`ifdef DIV_SIGNED_EN
    wait_res("div_7_m2", 32'hFFFF_FFFD, 32'h1, 1'b0, 1'b0, 33);
`else
    wait_res("div_7_m2", 32'h0, 32'h7, 1'b0, 1'b0, 33);
`endif
    launch(32'hFFFF_FFF0, 32'h0, 1'b1);
    wait_res("div0_s", 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0, 1);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_res("divu_max", 32'h1, 32'h0, 1'b0, 1'b0, 33);
    launch(32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_res("divu_by1", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 33);
    launch(32'h0, 32'd5, 1'b0);
    wait_res("divu_0_5", 32'h0, 32'h0, 1'b0, 1'b0, 33);
    @(negedge clock);
    launch(32'd200, 32'd7, 1'b0);
    repeat (8) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_ready", 32'(bus.ready), 32'(1));
    nv = 0;
    repeat (40) begin
      @(negedge clock);
      nv += int'(bus.result_valid);
    end
    chk("flush_no_valid", 32'(nv), 32'(0));
    launch(32'd9, 32'd3, 1'b0);
    wait_res("divu_9_3", 32'd3, 32'd0, 1'b0, 1'b0, 33);
    launch(32'd1000, 32'd10, 1'b0);
    repeat (5) @(negedge clock);
    bus.start = 1'b1;
    bus.dividend = 32'd5;
    bus.divisor = 32'd1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_res("divu_1000_10", 32'd100, 32'd0, 1'b0, 1'b0, 33);
    launch(32'd77, 32'd5, 1'b0);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'(1));
    chk("mid_rst_q", bus.quotient, 32'h0);
    chk("mid_rst_r", bus.remainder, 32'h0);
    chk("mid_rst_valid", 32'(bus.result_valid), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    launch(32'd50, 32'd5, 1'b0);
    wait_res("divu_50_5", 32'd10, 32'd0, 1'b0, 1'b0, 33);
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
